// File: rtl/vga_screen_ctrl.sv
// Screen sequencer for the VGA output mux.
// Walks blank -> intro -> menu -> game -> score on button pulses and the
// game-over flag. Produces the mux select, a frame-aligned intro blink, the
// play-logic enable and a one-cycle screen-change strobe. All outputs are
// registered and take the value of the next state in the same edge that
// decides the transition.
module vga_screen_ctrl #(
    parameter int IDLE_CYCLES  = 1_000_000,
    parameter int BLINK_HALF   = 25_000_000,
    parameter int SCORE_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_start,
    input  logic       btn_back,
    input  logic       game_over,
    input  logic       vsync_in,
    output logic [3:0] vga_control,
    output logic       blink,
    output logic       game_en,
    output logic       screen_chg
);

    // Dwell counter covers the longest timed interval; blink counter covers
    // one blink half-period.
    localparam int MAX_AB = (IDLE_CYCLES > BLINK_HALF) ? IDLE_CYCLES : BLINK_HALF;
    localparam int MAX_P  = (MAX_AB > SCORE_CYCLES) ? MAX_AB : SCORE_CYCLES;
    localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;
    localparam int BLK_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SCORE_LAST = CNT_W'(SCORE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};
    localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_HALF - 1);

    typedef enum logic [2:0] {
        ST_BLANK = 3'd0,
        ST_INTRO = 3'd1,
        ST_MENU  = 3'd2,
        ST_GAME  = 3'd3,
        ST_SCORE = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             state_chg;
    logic [CNT_W-1:0] dwell_cnt;
    logic [BLK_W-1:0] blk_cnt;
    logic             toggle_pending;
    logic             vsync_prev;
    logic             frame_fall;
    logic             intro_stay;
    logic             blk_wrap;

    // Next-state selection; priorities resolve coincident events.
    always_comb begin
        state_nxt = ST_BLANK;
        case (state)
            ST_BLANK: begin
                // Buttons are deliberately ignored while the blank hold runs.
                if (dwell_cnt == IDLE_LAST) state_nxt = ST_INTRO;
                else                        state_nxt = ST_BLANK;
            end
            ST_INTRO: begin
                if (btn_start) state_nxt = ST_MENU;
                else           state_nxt = ST_INTRO;
            end
            ST_MENU: begin
                // Back wins over start when both pulse together.
                if (btn_back)       state_nxt = ST_INTRO;
                else if (btn_start) state_nxt = ST_GAME;
                else                state_nxt = ST_MENU;
            end
            ST_GAME: begin
                // A finished game always reaches the score screen, even on abort.
                if (game_over)     state_nxt = ST_SCORE;
                else if (btn_back) state_nxt = ST_MENU;
                else               state_nxt = ST_GAME;
            end
            ST_SCORE: begin
                // A user confirm beats a timeout expiring in the same cycle.
                if (btn_start)                    state_nxt = ST_MENU;
                else if (dwell_cnt == SCORE_LAST) state_nxt = ST_INTRO;
                else                              state_nxt = ST_SCORE;
            end
            default: state_nxt = ST_BLANK;
        endcase
    end

    // Blink-timing helpers: falling vsync marks a frame boundary; the blink
    // counter only advances while the intro screen is held.
    always_comb begin
        state_chg  = (state_nxt != state);
        frame_fall = vsync_prev & ~vsync_in;
        intro_stay = (state == ST_INTRO) && (state_nxt == ST_INTRO);
        blk_wrap   = intro_stay && (blk_cnt == BLK_LAST);
    end

    // State register and registered mux-facing outputs, all updated together.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= ST_BLANK;
            vga_control <= 4'd0;
            game_en     <= 1'b0;
            screen_chg  <= 1'b0;
        end else begin
            state       <= state_nxt;
            vga_control <= {1'b0, state_nxt};
            game_en     <= (state_nxt == ST_GAME);
            screen_chg  <= state_chg;
        end
    end

    // Shared dwell counter: restarts on every screen change and saturates.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            dwell_cnt <= '0;
        end else if (state_chg) begin
            dwell_cnt <= '0;
        end else if (dwell_cnt != CNT_SAT) begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
        end
    end

    // Intro blink: wraps arm a single pending toggle, applied on the next
    // frame boundary so the blanking never tears mid-frame.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            vsync_prev     <= 1'b1;
            blk_cnt        <= '0;
            toggle_pending <= 1'b0;
            blink          <= 1'b0;
        end else begin
            vsync_prev <= vsync_in;
            if (!intro_stay) begin
                // Entering or leaving intro (or any other screen): blink off.
                blk_cnt        <= '0;
                toggle_pending <= 1'b0;
                blink          <= 1'b0;
            end else begin
                blk_cnt <= blk_wrap ? '0 : blk_cnt + BLK_W'(1);
                if (frame_fall && toggle_pending) blink <= ~blink;
                // A fresh wrap re-arms even if this boundary consumed the old one.
                if (blk_wrap)        toggle_pending <= 1'b1;
                else if (frame_fall) toggle_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_screen_ctrl.sv
// Scoreboard bench for vga_screen_ctrl with short timing parameters.
module tb_vga_screen_ctrl;

    localparam int IDLE  = 4;
    localparam int BHALF = 8;
    localparam int SCORE = 20;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_back = 1'b0;
    logic       game_over = 1'b0;
    logic       vsync_in = 1'b1;
    logic [3:0] vga_control;
    logic       blink;
    logic       game_en;
    logic       screen_chg;

    vga_screen_ctrl #(
        .IDLE_CYCLES (IDLE),
        .BLINK_HALF  (BHALF),
        .SCORE_CYCLES(SCORE)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .btn_start  (btn_start),
        .btn_back   (btn_back),
        .game_over  (game_over),
        .vsync_in   (vsync_in),
        .vga_control(vga_control),
        .blink      (blink),
        .game_en    (game_en),
        .screen_chg (screen_chg)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [6:0] sb_q[$];

    // Reference model state
    int m_scr   = 0;
    int m_time  = 0;
    int m_bcnt  = 0;
    bit m_arm   = 0;
    bit m_blink = 0;
    bit m_vprev = 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_scr   = 0;
        m_time  = 0;
        m_bcnt  = 0;
        m_arm   = 0;
        m_blink = 0;
        m_vprev = 1;
    endtask

    // Predict the outputs after the coming clock edge from the current inputs.
    task automatic model_step(output logic [6:0] exp);
        int  nxt;
        bit  fall;
        bit  wrapped;
        bit  flip;
        nxt = m_scr;
        case (m_scr)
            0: if (m_time == IDLE - 1) nxt = 1;
            1: if (btn_start) nxt = 2;
            2: nxt = btn_back ? 1 : (btn_start ? 3 : 2);
            3: nxt = game_over ? 4 : (btn_back ? 2 : 3);
            4: nxt = btn_start ? 2 : ((m_time == SCORE - 1) ? 1 : 4);
            default: nxt = 0;
        endcase
        fall = m_vprev && !vsync_in;
        if (m_scr == 1 && nxt == 1) begin
            wrapped = (m_bcnt == BHALF - 1);
            flip    = fall && m_arm;
            if (flip) m_blink = !m_blink;
            if (wrapped)   m_arm = 1;
            else if (flip) m_arm = 0;
            m_bcnt = wrapped ? 0 : m_bcnt + 1;
        end else begin
            m_bcnt  = 0;
            m_arm   = 0;
            m_blink = 0;
        end
        exp = {4'(nxt), m_blink, (nxt == 3), (nxt != m_scr)};
        m_time  = (nxt != m_scr) ? 0 : m_time + 1;
        m_scr   = nxt;
        m_vprev = vsync_in;
    endtask

    task automatic step();
        logic [6:0] e;
        logic [6:0] got;
        model_step(e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = {vga_control, blink, game_en, screen_chg};
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val($sformatf("cyc%0d", cyc), 32'(got), 32'(e));
        end
        btn_start = 1'b0;
        btn_back  = 1'b0;
        cyc++;
        if (cyc % 5 == 0) vsync_in = ~vsync_in;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Power-on reset
        #2;
        check_val("rst_vga", 32'(vga_control), 32'd0);
        check_val("rst_blink", 32'(blink), 32'd0);
        check_val("rst_game_en", 32'(game_en), 32'd0);
        check_val("rst_chg", 32'(screen_chg), 32'd0);
        @(posedge clk);
        #1;
        model_reset();
        clr = 1'b1;

        // Blank hold; buttons must be ignored
        for (int i = 0; i < 3; i++) begin
            btn_start = 1'b1;
            btn_back  = 1'b1;
            step();
        end
        check_val("blank_hold", 32'(vga_control), 32'd0);
        check_val("no_chg_release", 32'(screen_chg), 32'd0);
        btn_start = 1'b1;
        step();
        check_val("intro_entry", 32'(vga_control), 32'd1);
        check_val("intro_chg", 32'(screen_chg), 32'd1);

        // Intro held 40 cycles, back ignored
        for (int i = 0; i < 40; i++) begin
            if (i == 10) btn_back = 1'b1;
            step();
        end
        check_val("intro_held", 32'(vga_control), 32'd1);
        btn_start = 1'b1;
        step();
        check_val("menu_entry", 32'(vga_control), 32'd2);
        check_val("menu_blink0", 32'(blink), 32'd0);
        step();
        check_val("chg_single", 32'(screen_chg), 32'd0);

        // Menu: back beats start
        btn_start = 1'b1;
        btn_back  = 1'b1;
        step();
        check_val("menu_both", 32'(vga_control), 32'd1);
        steps(3);
        btn_start = 1'b1;
        step();
        btn_start = 1'b1;
        step();
        check_val("game_entry", 32'(vga_control), 32'd3);
        check_val("game_en_on", 32'(game_en), 32'd1);
        steps(5);

        // Game: game_over beats back
        game_over = 1'b1;
        btn_back  = 1'b1;
        step();
        game_over = 1'b0;
        check_val("score_entry", 32'(vga_control), 32'd4);
        check_val("game_en_off", 32'(game_en), 32'd0);
        steps(19);
        check_val("score_dwell", 32'(vga_control), 32'd4);
        step();
        check_val("score_timeout", 32'(vga_control), 32'd1);

        // Score: start coincident with timeout wins
        btn_start = 1'b1;
        step();
        btn_start = 1'b1;
        step();
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        steps(19);
        btn_start = 1'b1;
        step();
        check_val("score_start_wins", 32'(vga_control), 32'd2);

        // Game re-entry with game_over still high exits straight to score
        game_over = 1'b1;
        btn_start = 1'b1;
        step();
        check_val("reentry_game", 32'(vga_control), 32'd3);
        step();
        check_val("reentry_score", 32'(vga_control), 32'd4);
        game_over = 1'b0;
        btn_start = 1'b1;
        step();
        btn_start = 1'b1;
        step();
        steps(3);

        // Asynchronous reset mid-game
        #2;
        clr = 1'b0;
        #1;
        check_val("arst_vga", 32'(vga_control), 32'd0);
        check_val("arst_game_en", 32'(game_en), 32'd0);
        check_val("arst_blink", 32'(blink), 32'd0);
        check_val("arst_chg", 32'(screen_chg), 32'd0);
        model_reset();
        #2;
        clr = 1'b1;
        steps(3);
        check_val("arst_blank", 32'(vga_control), 32'd0);
        step();
        check_val("arst_intro", 32'(vga_control), 32'd1);
        steps(20);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

endmodule
